// File: rtl/boot_loader_pkg.sv
// boot_loader shared types: FSM states, MOV size codes, RW codes.
// BOOT_LOADER_VERIFY_EN adds the VERIFY readback state.
package boot_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
`ifdef BOOT_LOADER_VERIFY_EN
    S_VERIFY,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;

  localparam logic WRITE = 1'b1;
  localparam logic READ  = 1'b0;

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream handshake plus MFA/MFC RAM port of the boot loader.
// master = loader side, slave = byte source and RAM side.
interface boot_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DW     = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_byte;
  logic              in_last;
  logic              MFA;
  logic              RW_RAM;
  logic [1:0]        MOV;
  logic [ADDR_W-1:0] mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              MFC;

  modport master (
    input  in_valid, in_byte, in_last,
    output in_ready,
    output MFA, RW_RAM, MOV,
    output mem_addr, mem_wdata,
    input  mem_rdata, MFC
  );

  modport slave (
    output in_valid, in_byte, in_last,
    input  in_ready,
    input  MFA, RW_RAM, MOV,
    input  mem_addr, mem_wdata,
    output mem_rdata, MFC
  );

endinterface

// File: rtl/boot_loader_byte_packer.sv
// Big-endian byte-to-word packer; first byte lands in the top byte.
// A flush on a partial word leaves the unwritten low bytes at zero.
module byte_packer #(
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    push_i,
  input  logic                    flush_i,
  input  logic [7:0]              byte_i,
  output logic [8*WORD_BYTES-1:0] word_o,
  output logic                    word_full_o
);

  localparam int DW = 8 * WORD_BYTES;
  localparam int CW =
    (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [DW-1:0] word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    word_o = word_q;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (cnt_q == CW'(i))
        word_o[DW-1-8*i -: 8] = byte_i;
    end
    word_full_o = push_i &
      (cnt_q == CW'(WORD_BYTES - 1));
  end

  // Register is zeroed after each hand-off so a flush zero-fills.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (push_i) begin
      if (word_full_o | flush_i) begin
        word_d = '0;
        cnt_d  = '0;
      end else begin
        word_d = word_o;
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Byte-stream program loader into RAM over MFA/MFC; holds core in reset.
// BOOT_LOADER_VERIFY_EN adds a readback compare after every write.
module boot_loader
  import boot_pkg::*;
#(
  parameter int WORD_BYTES  = 4,
  parameter int ADDR_W      = 8,
  parameter int BASE_ADDR   = 0,
  parameter int MAX_WORDS   = 64,
  parameter int MFC_TIMEOUT = 16
) (
  input  logic CLK,
  input  logic Reset,
  input  logic start,
  boot_loader_if.master bus,
  output logic core_reset_n,
  output logic done,
  output logic error,
  output logic [$clog2(MAX_WORDS+1)-1:0] words_loaded
);

  localparam int DW  = 8 * WORD_BYTES;
  localparam int WLW = $clog2(MAX_WORDS + 1);
  localparam int TW  = $clog2(MFC_TIMEOUT + 1);

  state_t state_q, state_d;

  logic              in_ready_q, in_ready_d;
  logic              mfa_q, mfa_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              crn_q, crn_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [WLW-1:0]    words_q, words_d;
  logic              last_q, last_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic          xfer, ovf, push;
  logic          word_full, word_end;
  logic          mfc_ok, tmo_hit;
  logic          restart, adv;
  logic [DW-1:0] packed_w;

  assign xfer     = bus.in_valid & in_ready_q;
  assign ovf      = xfer &
    (words_q == WLW'(MAX_WORDS));
  assign push     = xfer & ~ovf;
  assign word_end = push &
    (word_full | bus.in_last);
  assign mfc_ok   = mfa_q & bus.MFC;
  assign tmo_hit  = mfa_q & ~bus.MFC &
    (tmo_q == TW'(MFC_TIMEOUT - 1));
  assign restart  = start &
    (state_q == S_IDLE || state_q == S_DONE);

`ifdef BOOT_LOADER_VERIFY_EN
  logic vfy_bad;
  assign vfy_bad = (bus.mem_rdata != wdata_q);
  assign adv     = (state_q == S_VERIFY) & mfc_ok;
`else
  logic unused_rdata;
  assign unused_rdata = ^bus.mem_rdata;
  assign adv          = (state_q == S_WRITE) & mfc_ok;
`endif

  byte_packer #(
    .WORD_BYTES (WORD_BYTES)
  ) u_pack (
    .clk         (CLK),
    .rst_n       (Reset),
    .clr_i       (restart),
    .push_i      (push),
    .flush_i     (bus.in_last),
    .byte_i      (bus.in_byte),
    .word_o      (packed_w),
    .word_full_o (word_full)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE:
        if (start) state_d = S_COLLECT;
      S_COLLECT:
        if (ovf)           state_d = S_ERROR;
        else if (word_end) state_d = S_WRITE;
      S_WRITE:
        if (mfc_ok) begin
`ifdef BOOT_LOADER_VERIFY_EN
          state_d = S_VERIFY;
`else
          state_d = last_q ? S_DONE : S_COLLECT;
`endif
        end else if (tmo_hit) begin
          state_d = S_ERROR;
        end
`ifdef BOOT_LOADER_VERIFY_EN
      S_VERIFY:
        if (mfc_ok) begin
          if (vfy_bad)     state_d = S_ERROR;
          else if (last_q) state_d = S_DONE;
          else             state_d = S_COLLECT;
        end else if (tmo_hit) begin
          state_d = S_ERROR;
        end
`endif
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the next state so every port is a flop.
  always_comb begin
    in_ready_d = (state_d == S_COLLECT);
`ifdef BOOT_LOADER_VERIFY_EN
    mfa_d = (state_d == S_WRITE) ||
            (state_d == S_VERIFY);
`else
    mfa_d = (state_d == S_WRITE);
`endif
    rw_d   = (state_d == S_WRITE) ? WRITE : READ;
    done_d = (state_d == S_DONE);
    crn_d  = (state_d == S_DONE);
    err_d  = (state_d == S_ERROR);

    addr_d  = addr_q;
    words_d = words_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    tmo_d   = (mfa_q && state_d == state_q) ?
              tmo_q + 1'b1 : '0;

    if (restart) begin
      addr_d  = ADDR_W'(BASE_ADDR);
      words_d = '0;
      last_d  = 1'b0;
    end
    if (word_end) begin
      wdata_d = packed_w;
      last_d  = bus.in_last;
    end
    if (state_q == S_WRITE && mfc_ok)
      words_d = words_q + 1'b1;
    if (adv)
      addr_d = addr_q + ADDR_W'(WORD_BYTES);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      in_ready_q <= 1'b0;
      mfa_q      <= 1'b0;
      rw_q       <= READ;
      addr_q     <= ADDR_W'(BASE_ADDR);
      wdata_q    <= '0;
      crn_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      words_q    <= '0;
      last_q     <= 1'b0;
      tmo_q      <= '0;
    end else begin
      in_ready_q <= in_ready_d;
      mfa_q      <= mfa_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      crn_q      <= crn_d;
      done_q     <= done_d;
      err_q      <= err_d;
      words_q    <= words_d;
      last_q     <= last_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.MFA       = mfa_q;
  assign bus.RW_RAM    = rw_q;
  assign bus.MOV       = WORD;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign core_reset_n  = crn_q;
  assign done          = done_q;
  assign error         = err_q;
  assign words_loaded  = words_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: word packing, timeout, overflow, reset.
// Readback-mismatch case runs when BOOT_LOADER_VERIFY_EN is defined.
module tb_boot_loader;

  localparam int WB = 4;
  localparam int AW = 8;
  localparam int MW = 2;
  localparam int TO = 16;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic       start = 1'b0;
  logic       core_reset_n;
  logic       done;
  logic       error;
  logic [1:0] words_loaded;

  boot_loader_if #(.ADDR_W(AW), .DW(32)) bif ();

  boot_loader #(
    .WORD_BYTES  (WB),
    .ADDR_W      (AW),
    .BASE_ADDR   (0),
    .MAX_WORDS   (MW),
    .MFC_TIMEOUT (TO)
  ) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .start        (start),
    .bus          (bif.master),
    .core_reset_n (core_reset_n),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // RAM model: MFC one cycle after MFA, write log for checking.
  logic        mfc_en = 1'b1;
  logic        flip = 1'b0;
  int          wr_cnt = 0;
  logic [7:0]  wa [0:31];
  logic [31:0] wd [0:31];
  logic [31:0] mem [0:63];

  always @(posedge CLK) begin
    if (!Reset) begin
      bif.MFC <= 1'b0;
    end else if (bif.MFA && !bif.MFC && mfc_en) begin
      bif.MFC <= 1'b1;
      if (bif.RW_RAM) begin
        mem[bif.mem_addr[7:2]] <= bif.mem_wdata;
        wa[wr_cnt[4:0]] <= bif.mem_addr;
        wd[wr_cnt[4:0]] <= bif.mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        bif.mem_rdata <= mem[bif.mem_addr[7:2]] ^
          {31'd0, (flip && bif.mem_addr == 8'd4)};
      end
    end else begin
      bif.MFC <= 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic check_rst(input string p);
    chk({p, "_in_ready"}, 32'(bif.in_ready), 0);
    chk({p, "_mfa"}, 32'(bif.MFA), 0);
    chk({p, "_rw"}, 32'(bif.RW_RAM), 0);
    chk({p, "_mov"}, 32'(bif.MOV), 2);
    chk({p, "_addr"}, 32'(bif.mem_addr), 0);
    chk({p, "_wdata"}, bif.mem_wdata, 0);
    chk({p, "_crn"}, 32'(core_reset_n), 0);
    chk({p, "_done"}, 32'(done), 0);
    chk({p, "_error"}, 32'(error), 0);
    chk({p, "_words"}, 32'(words_loaded), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b,
                      input logic last);
    int n = 0;
    bif.in_valid = 1'b1;
    bif.in_byte  = b;
    bif.in_last  = last;
    while (bif.in_ready !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 40) chk("in_ready_bound", 32'(n), 0);
    @(negedge CLK);
    bif.in_valid = 1'b0;
    bif.in_last  = 1'b0;
  endtask

  task automatic send_bytes(input logic [63:0] v,
                            input int cnt,
                            input logic last);
    for (int i = 0; i < cnt; i++)
      send(v[63-8*i -: 8], last && (i == cnt - 1));
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done === 1'b1 || error === 1'b1) &&
           n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) chk("end_bound", 32'(n), 0);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    bif.in_valid = 1'b0;
    bif.in_byte  = 8'h00;
    bif.in_last  = 1'b0;
    repeat (2) @(negedge CLK);
    check_rst("por");
    Reset = 1'b1;
    @(negedge CLK);
    chk("idle_ready", 32'(bif.in_ready), 0);

    // Two full words
    base = wr_cnt;
    pulse_start();
    chk("t1_ready", 32'(bif.in_ready), 1);
    chk("t1_crn_lo", 32'(core_reset_n), 0);
    send_bytes(64'hE3A01005_EAFFFFFE, 8, 1'b1);
    wait_end();
    chk("t1_nwr", 32'(wr_cnt - base), 2);
    chk("t1_a0", 32'(wa[base]), 32'h0);
    chk("t1_d0", wd[base], 32'hE3A01005);
    chk("t1_a1", 32'(wa[base+1]), 32'h4);
    chk("t1_d1", wd[base+1], 32'hEAFFFFFE);
    chk("t1_words", 32'(words_loaded), 2);
    chk("t1_done", 32'(done), 1);
    chk("t1_crn", 32'(core_reset_n), 1);
    chk("t1_err", 32'(error), 0);

    // Partial last word, restart from DONE
    base = wr_cnt;
    pulse_start();
    chk("t2_words0", 32'(words_loaded), 0);
    chk("t2_done0", 32'(done), 0);
    chk("t2_crn0", 32'(core_reset_n), 0);
    send_bytes(64'h11223344_55660000, 6, 1'b1);
    wait_end();
    chk("t2_nwr", 32'(wr_cnt - base), 2);
    chk("t2_d0", wd[base], 32'h11223344);
    chk("t2_a1", 32'(wa[base+1]), 32'h4);
    chk("t2_d1", wd[base+1], 32'h55660000);
    chk("t2_words", 32'(words_loaded), 2);
    chk("t2_done", 32'(done), 1);

    // MFC timeout
    mfc_en = 1'b0;
    pulse_start();
    send_bytes(64'hA1B2C3D4_00000000, 4, 1'b0);
    chk("t3_mfa", 32'(bif.MFA), 1);
    chk("t3_rw", 32'(bif.RW_RAM), 1);
    chk("t3_addr", 32'(bif.mem_addr), 0);
    chk("t3_wdata", bif.mem_wdata, 32'hA1B2C3D4);
    repeat (TO - 1) @(negedge CLK);
    chk("t3_err_early", 32'(error), 0);
    chk("t3_mfa_held", 32'(bif.MFA), 1);
    @(negedge CLK);
    chk("t3_err", 32'(error), 1);
    chk("t3_crn", 32'(core_reset_n), 0);
    chk("t3_done", 32'(done), 0);
    chk("t3_mfa_off", 32'(bif.MFA), 0);
    pulse_start();
    chk("t3_err_sticky", 32'(error), 1);
    mfc_en = 1'b1;
    do_reset();
    check_rst("t3rst");

    // Overflow past MAX_WORDS
    pulse_start();
    send_bytes(64'h01020304_05060708, 8, 1'b0);
    repeat (3) @(negedge CLK);
    chk("t4_words", 32'(words_loaded), 2);
    chk("t4_err0", 32'(error), 0);
    chk("t4_ready", 32'(bif.in_ready), 1);
    send(8'h09, 1'b0);
    chk("t4_err", 32'(error), 1);
    chk("t4_words_hold", 32'(words_loaded), 2);
    chk("t4_crn", 32'(core_reset_n), 0);
    do_reset();

    // Async reset while MFA high
    mfc_en = 1'b0;
    pulse_start();
    send_bytes(64'hAABBCCDD_00000000, 4, 1'b0);
    chk("t5_mfa", 32'(bif.MFA), 1);
    #2 Reset = 1'b0;
    #1 check_rst("t5");
    @(negedge CLK);
    Reset  = 1'b1;
    mfc_en = 1'b1;
    @(negedge CLK);
    base = wr_cnt;
    pulse_start();
    send_bytes(64'h01020304_00000000, 4, 1'b1);
    wait_end();
    chk("t5_nwr", 32'(wr_cnt - base), 1);
    chk("t5_a0", 32'(wa[base]), 32'h0);
    chk("t5_d0", wd[base], 32'h01020304);
    chk("t5_words", 32'(words_loaded), 1);
    chk("t5_done", 32'(done), 1);

`ifdef BOOT_LOADER_VERIFY_EN
    // Readback of word 1 corrupted
    do_reset();
    flip = 1'b1;
    base = wr_cnt;
    pulse_start();
    send_bytes(64'hE3A01005_EAFFFFFE, 8, 1'b1);
    wait_end();
    chk("t6_nwr", 32'(wr_cnt - base), 2);
    chk("t6_err", 32'(error), 1);
    chk("t6_done", 32'(done), 0);
    chk("t6_crn", 32'(core_reset_n), 0);
    flip = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
